// File: rtl/debug_pkg.sv
// Shared definitions for the operator debug entry block.
// Holds select codes, value limits and the entry FSM state type.
package debug_pkg;

    localparam logic [1:0] SEL_CHAL   = 2'b00;
    localparam logic [1:0] SEL_SPEED  = 2'b01;
    localparam logic [1:0] SEL_DIR_LO = 2'b10;
    localparam logic [1:0] SEL_DIR_HI = 2'b11;

    // updateSel code reported for a completed direction write
    localparam logic [1:0] UPD_DIR = 2'b10;

    localparam logic [6:0] MAX_SPEED = 7'd100;
    localparam logic [8:0] MAX_DIR   = 9'd359;

    typedef enum logic {
        IDLE,
        HAVE_LO
    } entry_state_t;

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter and
// press-event pulse on the debounced 1->0 edge.
// Ports: clk, reset (sync, active-high), key_raw (active-low, async),
//        key_state (debounced level), press (one-cycle press event).
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic key_state,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            key_state <= 1'b1;
            cnt       <= '0;
            press     <= 1'b0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 != key_state) begin
                // Accept on the DEBOUNCE_CYCLES-th consecutive differing sample
                if (cnt == CNT_LAST) begin
                    key_state <= sync2;
                    cnt       <= '0;
                    press     <= ~sync2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/debug_entry.sv
// Operator override entry from DE10-Lite switches and pushbuttons.
// Ports: CLOCK_50, reset (sync, active-high), SW[9:0], KEY[3:0] (active-low);
//        registered overrides, overrideEnable, updatePulse/updateSel, status.
module debug_entry
    import debug_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [9:0] SW,
    input  logic [3:0] KEY,
    output logic [2:0] challengeSelect,
    output logic [6:0] driveSpeedOverride,
    output logic [8:0] targetDirectionOverride,
    output logic       overrideEnable,
    output logic       updatePulse,
    output logic [1:0] updateSel,
    output logic       entryPending,
    output logic       entryError
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [2:0] key_state;
    logic [2:0] press;
    logic       commit;
    logic       cancel;
    logic       toggle;
    logic       unused_key;

    assign unused_key = ^{KEY[3], key_state, CNT_W[0]};

    for (genvar i = 0; i < 3; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk      (CLOCK_50),
            .reset    (reset),
            .key_raw  (KEY[i]),
            .key_state(key_state[i]),
            .press    (press[i])
        );
    end

    assign commit = press[0];
    assign cancel = press[1];
    assign toggle = press[2];

    entry_state_t state_q;
    entry_state_t state_d;
    logic [7:0]   staged_q;
    logic [7:0]   staged_d;
    logic [2:0]   chal_d;
    logic [6:0]   speed_d;
    logic [8:0]   dir_d;
    logic         en_d;
    logic         pulse_d;
    logic [1:0]   sel_d;
    logic         err_d;
    logic [8:0]   speed_ext;
    logic [8:0]   dir_val;

    assign speed_ext = {2'b00, SW[6:0]};
    assign dir_val   = {SW[0], staged_q};

    always_comb begin
        state_d  = state_q;
        staged_d = staged_q;
        chal_d   = challengeSelect;
        speed_d  = driveSpeedOverride;
        dir_d    = targetDirectionOverride;
        en_d     = overrideEnable ^ toggle;
        pulse_d  = 1'b0;
        sel_d    = updateSel;
        err_d    = entryError;
        // Cancel wins over a same-cycle commit
        if (cancel) begin
            state_d = IDLE;
            err_d   = 1'b0;
        end else if (commit) begin
            unique case (SW[9:8])
                SEL_CHAL: begin
                    chal_d  = SW[2:0];
                    pulse_d = 1'b1;
                    sel_d   = SEL_CHAL;
                end
                SEL_SPEED: begin
                    pulse_d = 1'b1;
                    sel_d   = SEL_SPEED;
                    if (speed_ext > {2'b00, MAX_SPEED}) begin
                        speed_d = MAX_SPEED;
                        err_d   = 1'b1;
                    end else begin
                        speed_d = SW[6:0];
                        err_d   = 1'b0;
                    end
                end
                SEL_DIR_LO: begin
                    staged_d = SW[7:0];
                    state_d  = HAVE_LO;
                    err_d    = 1'b0;
                end
                SEL_DIR_HI: begin
                    if (state_q == HAVE_LO) begin
                        pulse_d = 1'b1;
                        sel_d   = UPD_DIR;
                        state_d = IDLE;
                        if (dir_val > MAX_DIR) begin
                            dir_d = MAX_DIR;
                            err_d = 1'b1;
                        end else begin
                            dir_d = dir_val;
                            err_d = 1'b0;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q                 <= IDLE;
            staged_q                <= '0;
            challengeSelect         <= '0;
            driveSpeedOverride      <= '0;
            targetDirectionOverride <= '0;
            overrideEnable          <= 1'b0;
            updatePulse             <= 1'b0;
            updateSel               <= '0;
            entryPending            <= 1'b0;
            entryError              <= 1'b0;
        end else begin
            state_q                 <= state_d;
            staged_q                <= staged_d;
            challengeSelect         <= chal_d;
            driveSpeedOverride      <= speed_d;
            targetDirectionOverride <= dir_d;
            overrideEnable          <= en_d;
            updatePulse             <= pulse_d;
            updateSel               <= sel_d;
            entryPending            <= (state_d == HAVE_LO);
            entryError              <= err_d;
        end
    end

endmodule

// File: tb/tb_debug_entry.sv
// Testbench for debug_entry: vector table, corner sequences,
// and randomized operations against a behavioural model.
module tb_debug_entry;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] SW = '0;
    logic [3:0] KEY = 4'hF;
    logic [2:0] challengeSelect;
    logic [6:0] driveSpeedOverride;
    logic [8:0] targetDirectionOverride;
    logic       overrideEnable;
    logic       updatePulse;
    logic [1:0] updateSel;
    logic       entryPending;
    logic       entryError;

    always #10 CLOCK_50 = ~CLOCK_50;

    debug_entry #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .CLOCK_50               (CLOCK_50),
        .reset                  (reset),
        .SW                     (SW),
        .KEY                    (KEY),
        .challengeSelect        (challengeSelect),
        .driveSpeedOverride     (driveSpeedOverride),
        .targetDirectionOverride(targetDirectionOverride),
        .overrideEnable         (overrideEnable),
        .updatePulse            (updatePulse),
        .updateSel              (updateSel),
        .entryPending           (entryPending),
        .entryError             (entryError)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int pulse_cnt = 0;

    always @(negedge CLOCK_50) if (updatePulse) pulse_cnt++;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // keys bit0 commit, bit1 cancel, bit2 toggle; held low for hold cycles
    task automatic op(input logic [2:0] keys, input logic [9:0] sw,
                      input int hold, output int dp);
        int p0;
        @(negedge CLOCK_50);
        p0 = pulse_cnt;
        SW = sw;
        KEY = {1'b1, ~keys};
        repeat (hold) @(negedge CLOCK_50);
        KEY = 4'hF;
        repeat (10) @(negedge CLOCK_50);
        dp = pulse_cnt - p0;
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        KEY = 4'hF;
        reset = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b0;
        repeat (2) @(negedge CLOCK_50);
    endtask

    // Behavioural model
    int m_chal, m_speed, m_dir, m_en, m_pend, m_staged, m_err, m_sel;

    task automatic model_reset();
        m_chal = 0; m_speed = 0; m_dir = 0; m_en = 0;
        m_pend = 0; m_staged = 0; m_err = 0; m_sel = 0;
    endtask

    task automatic model_op(input logic [2:0] keys, input logic [9:0] sw,
                            output int dp);
        int v;
        dp = 0;
        if (keys[2]) m_en = 1 - m_en;
        if (keys[1]) begin
            m_pend = 0;
            m_err = 0;
        end else if (keys[0]) begin
            case (int'(sw[9:8]))
                0: begin m_chal = int'(sw[2:0]); dp = 1; m_sel = 0; end
                1: begin
                    v = int'(sw[6:0]);
                    m_err = (v > 100) ? 1 : 0;
                    m_speed = (v > 100) ? 100 : v;
                    dp = 1; m_sel = 1;
                end
                2: begin m_staged = int'(sw[7:0]); m_pend = 1; m_err = 0; end
                default: begin
                    if (m_pend == 1) begin
                        v = int'(sw[0]) * 256 + m_staged;
                        m_err = (v > 359) ? 1 : 0;
                        m_dir = (v > 359) ? 359 : v;
                        m_pend = 0; dp = 1; m_sel = 2;
                    end else begin
                        m_err = 1;
                    end
                end
            endcase
        end
    endtask

    task automatic check_all(input string tag, input int chal, input int spd,
                             input int dir, input int en, input int pend,
                             input int err, input int dp_act, input int dp,
                             input int sel);
        check({tag, " chal"}, int'(challengeSelect), chal);
        check({tag, " speed"}, int'(driveSpeedOverride), spd);
        check({tag, " dir"}, int'(targetDirectionOverride), dir);
        check({tag, " en"}, int'(overrideEnable), en);
        check({tag, " pend"}, int'(entryPending), pend);
        check({tag, " err"}, int'(entryError), err);
        check({tag, " pulses"}, dp_act, dp);
        check({tag, " sel"}, int'(updateSel), sel);
    endtask

    typedef struct {
        logic [2:0] keys;
        logic [9:0] sw;
        int chal, spd, dir, en, pend, err, dp, sel;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic [2:0] k, logic [9:0] s, int c, int sp,
                                int d, int e, int p, int er, int dp, int se);
        vec_t v;
        v.keys = k; v.sw = s; v.chal = c; v.spd = sp; v.dir = d;
        v.en = e; v.pend = p; v.err = er; v.dp = dp; v.sel = se;
        return v;
    endfunction

    initial begin
        int dp;
        int edp;
        logic [2:0] k;
        logic [9:0] s;

        vt.push_back(mk(3'b001, 10'h005, 5,   0,   0, 0, 0, 0, 1, 0));
        vt.push_back(mk(3'b001, 10'h178, 5, 100,   0, 0, 0, 1, 1, 1));
        vt.push_back(mk(3'b001, 10'h12D, 5,  45,   0, 0, 0, 0, 1, 1));
        vt.push_back(mk(3'b001, 10'h22C, 5,  45,   0, 0, 1, 0, 0, 1));
        vt.push_back(mk(3'b001, 10'h301, 5,  45, 300, 0, 0, 0, 1, 2));
        vt.push_back(mk(3'b001, 10'h280, 5,  45, 300, 0, 1, 0, 0, 2));
        vt.push_back(mk(3'b001, 10'h301, 5,  45, 359, 0, 0, 1, 1, 2));
        vt.push_back(mk(3'b001, 10'h164, 5, 100, 359, 0, 0, 0, 1, 1));
        vt.push_back(mk(3'b001, 10'h301, 5, 100, 359, 0, 0, 1, 0, 1));
        vt.push_back(mk(3'b001, 10'h267, 5, 100, 359, 0, 1, 0, 0, 1));
        vt.push_back(mk(3'b011, 10'h301, 5, 100, 359, 0, 0, 0, 0, 1));
        vt.push_back(mk(3'b100, 10'h000, 5, 100, 359, 1, 0, 0, 0, 1));
        vt.push_back(mk(3'b100, 10'h000, 5, 100, 359, 0, 0, 0, 0, 1));
        vt.push_back(mk(3'b001, 10'h267, 5, 100, 359, 0, 1, 0, 0, 1));
        vt.push_back(mk(3'b001, 10'h301, 5, 100, 359, 0, 0, 0, 1, 2));
        vt.push_back(mk(3'b001, 10'h2FF, 5, 100, 359, 0, 1, 0, 0, 2));
        vt.push_back(mk(3'b001, 10'h007, 7, 100, 359, 0, 1, 0, 1, 0));
        vt.push_back(mk(3'b001, 10'h300, 7, 100, 255, 0, 0, 0, 1, 2));
        vt.push_back(mk(3'b101, 10'h002, 2, 100, 255, 1, 0, 0, 1, 0));
        vt.push_back(mk(3'b110, 10'h301, 2, 100, 255, 0, 0, 0, 0, 0));

        // Reset state
        do_reset();
        check_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Glitch shorter than debounce window
        op(3'b001, 10'h005, 3, dp);
        check("glitch3 pulses", dp, 0);
        check("glitch3 chal", int'(challengeSelect), 0);

        // Exactly the debounce window is accepted
        op(3'b001, 10'h006, 4, dp);
        check("exact4 pulses", dp, 1);
        check("exact4 chal", int'(challengeSelect), 6);

        do_reset();
        foreach (vt[i]) begin
            op(vt[i].keys, vt[i].sw, 10, dp);
            check_all($sformatf("vec%0d", i), vt[i].chal, vt[i].spd,
                      vt[i].dir, vt[i].en, vt[i].pend, vt[i].err, dp,
                      vt[i].dp, vt[i].sel);
        end

        // Reset mid-entry discards the staged byte
        op(3'b001, 10'h2AA, 10, dp);
        check("stage pend", int'(entryPending), 1);
        do_reset();
        check_all("midreset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        op(3'b001, 10'h301, 10, dp);
        check("after reset hi err", int'(entryError), 1);
        check("after reset hi pulses", dp, 0);
        check("after reset hi dir", int'(targetDirectionOverride), 0);

        // Randomized operations against the model
        do_reset();
        model_reset();
        for (int i = 0; i < 80; i++) begin
            k = 3'($urandom_range(1, 7));
            if ($urandom_range(0, 3) != 0) k = 3'b001;
            s = 10'($urandom);
            op(k, s, 8, dp);
            model_op(k, s, edp);
            check_all($sformatf("rnd%0d", i), m_chal, m_speed, m_dir, m_en,
                      m_pend, m_err, dp, edp, m_sel);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
